// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 raster constants, coordinate width and frame-total helpers
// for the VGA timing generator and the pixel logic that consumes its coordinates.
package vga_timing_pkg;

    localparam int unsigned CoordW   = 10;
    localparam int unsigned MaxTotal = 1 << CoordW;

    localparam int unsigned DefHActive = 640;
    localparam int unsigned DefHFront  = 16;
    localparam int unsigned DefHSync   = 96;
    localparam int unsigned DefHBack   = 48;

    localparam int unsigned DefVActive = 480;
    localparam int unsigned DefVFront  = 10;
    localparam int unsigned DefVSync   = 2;
    localparam int unsigned DefVBack   = 33;

    function automatic int unsigned h_total(input int unsigned active, input int unsigned front,
                                            input int unsigned sync, input int unsigned back);
        return active + front + sync + back;
    endfunction

    function automatic int unsigned v_total(input int unsigned active, input int unsigned front,
                                            input int unsigned sync, input int unsigned back);
        return active + front + sync + back;
    endfunction

endpackage

// File: rtl/pixel_tick_gen.sv
// Prescaler dividing the system clock down to the pixel rate; pixel_tick is high
// for one clock in every CLK_DIV and held low while reset is asserted.
module pixel_tick_gen #(
    parameter int unsigned CLK_DIV = 2
) (
    input  logic Clock,
    input  logic reset,
    output logic pixel_tick
);

    localparam int unsigned DivW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DivW-1:0] DivLast = DivW'(CLK_DIV - 1);

    logic [DivW-1:0] div_q, div_d;
    logic            at_last;

    assign at_last = (div_q == DivLast);

    always_comb begin
        div_d = at_last ? '0 : div_q + DivW'(1);
    end

    always_ff @(posedge Clock or negedge reset) begin
        if (!reset) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end

    // With CLK_DIV = 1 the divider sits at its last value even in reset, so gate it.
    assign pixel_tick = reset && at_last;

endmodule

// File: rtl/vga_timing.sv
// Raster timing generator: pixel/line counters, sync and blanking decode, and
// line/frame strobes for a 640x480@60 frame (parameterisable).
module vga_timing
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_ACTIVE = DefHActive,
    parameter int unsigned H_FRONT  = DefHFront,
    parameter int unsigned H_SYNC   = DefHSync,
    parameter int unsigned H_BACK   = DefHBack,
    parameter int unsigned V_ACTIVE = DefVActive,
    parameter int unsigned V_FRONT  = DefVFront,
    parameter int unsigned V_SYNC   = DefVSync,
    parameter int unsigned V_BACK   = DefVBack,
    parameter int unsigned CLK_DIV  = 2,
    parameter bit          SYNC_POL = 1'b0
) (
    input  logic              Clock,
    input  logic              reset,
    output logic              pixel_tick,
    output logic              hsync,
    output logic              vsync,
    output logic              video_on,
    output logic [CoordW-1:0] pixel_x,
    output logic [CoordW-1:0] pixel_y,
    output logic              line_start,
    output logic              frame_start
);

    localparam int unsigned H_TOTAL = h_total(H_ACTIVE, H_FRONT, H_SYNC, H_BACK);
    localparam int unsigned V_TOTAL = v_total(V_ACTIVE, V_FRONT, V_SYNC, V_BACK);

    if (H_TOTAL > MaxTotal || V_TOTAL > MaxTotal) begin : g_bad_total
        $error("vga_timing: H_TOTAL/V_TOTAL exceed the 10-bit coordinate range");
    end
    if (CLK_DIV < 1) begin : g_bad_div
        $error("vga_timing: CLK_DIV must be at least 1");
    end

    localparam logic [CoordW-1:0] HLast      = CoordW'(H_TOTAL - 1);
    localparam logic [CoordW-1:0] VLast      = CoordW'(V_TOTAL - 1);
    localparam logic [CoordW-1:0] HActive    = CoordW'(H_ACTIVE);
    localparam logic [CoordW-1:0] VActive    = CoordW'(V_ACTIVE);
    localparam logic [CoordW-1:0] HSyncStart = CoordW'(H_ACTIVE + H_FRONT);
    localparam logic [CoordW-1:0] HSyncEnd   = CoordW'(H_ACTIVE + H_FRONT + H_SYNC);
    localparam logic [CoordW-1:0] VSyncStart = CoordW'(V_ACTIVE + V_FRONT);
    localparam logic [CoordW-1:0] VSyncEnd   = CoordW'(V_ACTIVE + V_FRONT + V_SYNC);

    logic [CoordW-1:0] x_q, x_d;
    logic [CoordW-1:0] y_q, y_d;
    logic              hsync_q, hsync_d;
    logic              vsync_q, vsync_d;
    logic              video_on_q, video_on_d;

    pixel_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_pixel_tick_gen (
        .Clock      (Clock),
        .reset      (reset),
        .pixel_tick (pixel_tick)
    );

    // Sync/blank flags decode the next-state counters so they line up with the coordinates.
    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (pixel_tick) begin
            if (x_q == HLast) begin
                x_d = '0;
                y_d = (y_q == VLast) ? '0 : y_q + CoordW'(1);
            end else begin
                x_d = x_q + CoordW'(1);
            end
        end
        hsync_d    = (x_d >= HSyncStart && x_d < HSyncEnd) ? SYNC_POL : ~SYNC_POL;
        vsync_d    = (y_d >= VSyncStart && y_d < VSyncEnd) ? SYNC_POL : ~SYNC_POL;
        video_on_d = (x_d < HActive) && (y_d < VActive);
    end

    always_ff @(posedge Clock or negedge reset) begin
        if (!reset) begin
            x_q        <= '0;
            y_q        <= '0;
            hsync_q    <= ~SYNC_POL;
            vsync_q    <= ~SYNC_POL;
            video_on_q <= 1'b1;
        end else begin
            x_q        <= x_d;
            y_q        <= y_d;
            hsync_q    <= hsync_d;
            vsync_q    <= vsync_d;
            video_on_q <= video_on_d;
        end
    end

    assign pixel_x     = x_q;
    assign pixel_y     = y_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign video_on    = video_on_q;
    assign line_start  = pixel_tick && (x_q == HLast);
    assign frame_start = line_start && (y_q == VLast);

endmodule

// File: tb/tb_vga_timing.sv
// Self-checking bench for vga_timing: default timing, a CLK_DIV=1/active-high
// variant, and a reduced-size raster for frame-level and reset corner cases.
module tb_vga_timing;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a, rst_b, rst_c;

    logic       a_tick, a_hs, a_vs, a_von, a_ls, a_fs;
    logic [9:0] a_x, a_y;
    logic       b_tick, b_hs, b_vs, b_von, b_ls, b_fs;
    logic [9:0] b_x, b_y;
    logic       c_tick, c_hs, c_vs, c_von, c_ls, c_fs;
    logic [9:0] c_x, c_y;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    vga_timing u_dut_a (
        .Clock(clk), .reset(rst_a), .pixel_tick(a_tick), .hsync(a_hs), .vsync(a_vs),
        .video_on(a_von), .pixel_x(a_x), .pixel_y(a_y), .line_start(a_ls), .frame_start(a_fs)
    );

    vga_timing #(
        .CLK_DIV(1), .SYNC_POL(1'b1)
    ) u_dut_b (
        .Clock(clk), .reset(rst_b), .pixel_tick(b_tick), .hsync(b_hs), .vsync(b_vs),
        .video_on(b_von), .pixel_x(b_x), .pixel_y(b_y), .line_start(b_ls), .frame_start(b_fs)
    );

    // Reduced raster: H_TOTAL = 15 (hsync x 10..12), V_TOTAL = 13 (vsync y 8..9).
    vga_timing #(
        .H_ACTIVE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
        .V_ACTIVE(6), .V_FRONT(2), .V_SYNC(2), .V_BACK(3),
        .CLK_DIV(2), .SYNC_POL(1'b0)
    ) u_dut_c (
        .Clock(clk), .reset(rst_c), .pixel_tick(c_tick), .hsync(c_hs), .vsync(c_vs),
        .video_on(c_von), .pixel_x(c_x), .pixel_y(c_y), .line_start(c_ls), .frame_start(c_fs)
    );

    typedef struct {
        logic        rst;
        int unsigned adv;
        logic        tick;
        int unsigned x;
        int unsigned y;
        logic        hs;
        logic        vs;
        logic        von;
        logic        ls;
        logic        fs;
    } vec_t;

    vec_t vecs[13];

    task automatic step(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int unsigned act, input int unsigned exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    initial begin
        int unsigned hs_n, vs_n, von_n, ls_n, fs_n, tick_n;
        bit          found;

        // rst, adv, tick, x, y, hs, vs, von, ls, fs  (edges counted from release)
        vecs[0]  = '{1'b0, 1,    1'b0, 0,   0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 0,    1'b0, 0,   0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 1,    1'b1, 0,   0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[3]  = '{1'b1, 1,    1'b0, 1,   0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[4]  = '{1'b1, 1,    1'b1, 1,   0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[5]  = '{1'b1, 1275, 1'b0, 639, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[6]  = '{1'b1, 2,    1'b0, 640, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{1'b1, 30,   1'b0, 655, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{1'b1, 2,    1'b0, 656, 0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{1'b1, 190,  1'b0, 751, 0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{1'b1, 2,    1'b0, 752, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[11] = '{1'b1, 95,   1'b1, 799, 0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[12] = '{1'b1, 1,    1'b0, 0,   1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

        rst_a = 1'b1;
        rst_b = 1'b1;
        rst_c = 1'b1;
        #2;
        rst_a = 1'b0;
        rst_b = 1'b0;
        rst_c = 1'b0;

        // Default timing: table walk across reset, release and one line.
        for (int i = 0; i < 13; i++) begin
            rst_a = vecs[i].rst;
            step(vecs[i].adv);
            check($sformatf("vec%0d.tick", i), a_tick, vecs[i].tick);
            check($sformatf("vec%0d.x", i), a_x, vecs[i].x);
            check($sformatf("vec%0d.y", i), a_y, vecs[i].y);
            check($sformatf("vec%0d.hsync", i), a_hs, vecs[i].hs);
            check($sformatf("vec%0d.vsync", i), a_vs, vecs[i].vs);
            check($sformatf("vec%0d.video_on", i), a_von, vecs[i].von);
            check($sformatf("vec%0d.line_start", i), a_ls, vecs[i].ls);
            check($sformatf("vec%0d.frame_start", i), a_fs, vecs[i].fs);
        end

        // One full 1600-clock line from x = 0, y = 1.
        hs_n = 0; ls_n = 0; von_n = 0; tick_n = 0; vs_n = 0;
        for (int i = 0; i < 1600; i++) begin
            step(1);
            if (!a_hs) hs_n++;
            if (!a_vs) vs_n++;
            if (a_ls) ls_n++;
            if (a_von) von_n++;
            if (a_tick) tick_n++;
        end
        check("line.hsync_clocks", hs_n, 192);
        check("line.vsync_clocks", vs_n, 0);
        check("line.line_start_pulses", ls_n, 1);
        check("line.video_on_clocks", von_n, 1280);
        check("line.ticks", tick_n, 800);
        check("line.end_x", a_x, 0);
        check("line.end_y", a_y, 2);

        // CLK_DIV = 1, active-high syncs.
        check("fast.reset_tick", b_tick, 0);
        check("fast.reset_hsync", b_hs, 0);
        check("fast.reset_video_on", b_von, 1);
        rst_b = 1'b1;
        #1;
        check("fast.release_tick", b_tick, 1);
        step(1);
        check("fast.first_x", b_x, 1);
        hs_n = 0; ls_n = 0; tick_n = 0;
        for (int i = 0; i < 800; i++) begin
            step(1);
            if (b_hs) hs_n++;
            if (b_ls) ls_n++;
            if (b_tick) tick_n++;
        end
        check("fast.hsync_clocks", hs_n, 96);
        check("fast.line_start_pulses", ls_n, 1);
        check("fast.ticks", tick_n, 800);
        check("fast.vsync_idle", b_vs, 0);

        // Reduced raster: one full 390-clock frame.
        check("small.reset_x", c_x, 0);
        rst_c = 1'b1;
        #1;
        hs_n = 0; vs_n = 0; von_n = 0; ls_n = 0; fs_n = 0;
        for (int i = 0; i < 390; i++) begin
            step(1);
            if (!c_hs) hs_n++;
            if (!c_vs) vs_n++;
            if (c_von) von_n++;
            if (c_ls) ls_n++;
            if (c_fs) fs_n++;
        end
        check("frame.frame_start_pulses", fs_n, 1);
        check("frame.line_start_pulses", ls_n, 13);
        check("frame.vsync_clocks", vs_n, 60);
        check("frame.hsync_clocks", hs_n, 78);
        check("frame.video_on_clocks", von_n, 96);

        // Wrap corner: frame_start at the last pixel, then (0,0) with video_on.
        found = 1'b0;
        for (int i = 0; i < 400 && !found; i++) begin
            step(1);
            if (c_fs) found = 1'b1;
        end
        check("wrap.frame_start_seen", found, 1);
        check("wrap.x_last", c_x, 14);
        check("wrap.y_last", c_y, 12);
        check("wrap.tick", c_tick, 1);
        check("wrap.line_start", c_ls, 1);
        step(1);
        check("wrap.x0", c_x, 0);
        check("wrap.y0", c_y, 0);
        check("wrap.video_on", c_von, 1);
        check("wrap.frame_start_low", c_fs, 0);

        // Reset asserted inside vsync.
        found = 1'b0;
        for (int i = 0; i < 400 && !found; i++) begin
            step(1);
            if (c_y == 10'd9) found = 1'b1;
        end
        check("vrst.reached_y9", found, 1);
        check("vrst.vsync_active", c_vs, 0);
        rst_c = 1'b0;
        #1;
        check("vrst.vsync", c_vs, 1);
        check("vrst.hsync", c_hs, 1);
        check("vrst.x", c_x, 0);
        check("vrst.y", c_y, 0);
        check("vrst.video_on", c_von, 1);
        check("vrst.tick", c_tick, 0);
        check("vrst.line_start", c_ls, 0);
        check("vrst.frame_start", c_fs, 0);
        step(3);
        check("vrst.hold_x", c_x, 0);
        check("vrst.hold_tick", c_tick, 0);
        rst_c = 1'b1;
        step(2);
        check("vrst.restart_x", c_x, 1);
        check("vrst.restart_y", c_y, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/vga_timing.md
# vga_timing

Raster timing generator feeding the `digits` pixel generator and its 4-bit VGA adapter. It divides the system clock to a pixel rate and runs horizontal and vertical counters over a 640x480@60 frame. From those counters it produces hsync, vsync, the active-video flag, the current pixel coordinate, and frame/line strobes. All downstream pixel logic takes its position and blanking information from this block only.

## Interface
Parameters:
- `H_ACTIVE`, 640: visible pixels per line.
- `H_FRONT`, 16: horizontal front porch, in pixels.
- `H_SYNC`, 96: hsync width, in pixels.
- `H_BACK`, 48: horizontal back porch, in pixels.
- `V_ACTIVE`, 480: visible lines.
- `V_FRONT`, 10: vertical front porch, in lines.
- `V_SYNC`, 2: vsync width, in lines.
- `V_BACK`, 33: vertical back porch, in lines.
- `CLK_DIV`, 2: system clocks per pixel; must be ≥ 1.
- `SYNC_POL`, 0: active level of hsync and vsync (0 = active-low).

Ports:
- `Clock` in 1: system clock. One clock domain; reset is asynchronous and active-low.
- `reset` in 1: asynchronous, active-low.
- `pixel_tick` out 1: high for one clock each pixel period.
- `hsync` out 1: horizontal sync, registered.
- `vsync` out 1: vertical sync, registered.
- `video_on` out 1: current pixel lies in the active area, registered.
- `pixel_x` out 10: horizontal count, 0 to H_TOTAL-1.
- `pixel_y` out 10: vertical count, 0 to V_TOTAL-1.
- `line_start` out 1: one-clock strobe before each new line.
- `frame_start` out 1: one-clock strobe before each new frame.

## Operation
- Derived totals: H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK = 800; V_TOTAL = 525.
- Prescaler `div`:
  - Counts 0 to CLK_DIV-1 and wraps.
  - `pixel_tick` = (div == CLK_DIV-1).
  - With CLK_DIV = 1, `pixel_tick` is constantly high once out of reset.
- Counters advance only on a clock edge where `pixel_tick` is high:
  - `pixel_x` increments and wraps from H_TOTAL-1 to 0.
  - On that wrap, `pixel_y` increments and wraps from V_TOTAL-1 to 0.
- Sync and blanking decode:
  - hsync is active for H_ACTIVE+H_FRONT ≤ x < H_ACTIVE+H_FRONT+H_SYNC, i.e. 656 to 751.
  - vsync is active for 490 ≤ y < 492.
  - `video_on` = (x < H_ACTIVE) && (y < V_ACTIVE).
  - The active level of hsync/vsync is SYNC_POL; the inactive level is its inverse.
- Strobes:
  - `line_start` = pixel_tick && x == H_TOTAL-1.
  - `frame_start` = line_start && y == V_TOTAL-1.
  - Both are combinational from registered state and occur exactly in the clock before the counters change.
- Width rule: all comparisons are unsigned at 10 bits. Any parameter set with H_TOTAL or V_TOTAL > 1024 is illegal; reject it with an elaboration-time check.

## Timing
- `hsync`, `vsync` and `video_on` are registered from the next-state counter values. They therefore change on the same edge as `pixel_x`/`pixel_y`, with zero lag relative to the coordinate outputs.
- Reset state (asynchronous, while `reset` = 0):
  - div = 0, pixel_x = 0, pixel_y = 0.
  - hsync = vsync = inactive, i.e. ~SYNC_POL.
  - video_on = 1, the decode of (0,0).
  - pixel_tick, line_start and frame_start = 0, forced low during reset.
- After reset release:
  - The first `pixel_tick` occurs in clock CLK_DIV after release (clock 1 is the first edge).
  - The first counter advance happens on that edge.
- Reset asserted mid-frame: all state returns to the reset values immediately. No partial sync pulse persists.
- Frame period = CLK_DIV × 800 × 525 clocks; 840000 clocks for CLK_DIV = 2.

## Structure
- Package `vga_timing_pkg` holds the 640x480@60 default constants, the coordinate width (10), and the H_TOTAL/V_TOTAL derivation functions. `digits` imports the same package for its coordinate width.
- Sub-module `pixel_tick_gen` contains the prescaler, parameterised by CLK_DIV, with output `pixel_tick`.
- The counters, the decode and the output registers live in the top of this block.

## Test plan
- Reset release, CLK_DIV = 2 → `pixel_tick` first high at clock 2. Thereafter it is high every 2nd clock, and `pixel_x` reads 1 after the 2nd clock.
- Free run, one line → hsync is active for exactly 192 clocks starting when pixel_x becomes 656. The line period is 1600 clocks and `line_start` pulses once per line.
- Free run, one frame → vsync is active for 3200 clocks starting at pixel_y = 490. `frame_start` pulses once per 840000 clocks. `video_on` is high for 640 × 480 × 2 = 614400 clocks per frame.
- Wrap corner → at x = 799, y = 524 with `pixel_tick` high, `frame_start` = 1. On the next edge, x = 0, y = 0 and video_on = 1 together.
- Reset asserted at pixel_y = 491 (inside vsync) → vsync goes inactive asynchronously and all outputs take their reset values. Re-release restarts at (0,0).
- CLK_DIV = 1, SYNC_POL = 1 → `pixel_tick` is constantly 1. hsync is high for exactly 96 clocks per 800-clock line.
